instruction_refill_ctrl: RTL and testbench
==========================================

INSTRUCTION_REFILL_CTRL -- requirements
Module: instruction_refill_ctrl

Interface
REQ-001 Parameter ADDRW, default 32, SHALL set the byte-address width.
REQ-002 Parameter INW, default 512, SHALL set the cache line width in bits; line = INW/8 = 64 bytes.
REQ-003 Parameter BEATW, default 64, SHALL set the memory return width; BEATS = INW/BEATW = 8.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 Port pc_in  input  ADDRW  SHALL carry the byte address the fetch stage wants.
REQ-007 Port fetch_req  input  1  SHALL indicate that pc_in is a live fetch this cycle.
REQ-008 Port cache_valid  input  1  SHALL carry the instruction cache hit indication for pc_in.
REQ-009 Port flush  input  1  SHALL request abort of any in-flight refill (redirect).
REQ-010 Port mem_req  output  1  SHALL request a line read from memory.
REQ-011 Port mem_addr  output  ADDRW  SHALL carry the line-aligned read address.
REQ-012 Port mem_ack  input  1  SHALL indicate memory accepted the request this cycle.
REQ-013 Port mem_rdata  input  BEATW  SHALL carry one returned beat.
REQ-014 Port mem_rvalid  input  1  SHALL qualify mem_rdata.
REQ-015 Port cache_write  output  1  SHALL pulse the instruction cache line write.
REQ-016 Port cache_data  output  INW  SHALL carry the assembled line.
REQ-017 Port cache_base_addr  output  ADDRW  SHALL carry the line base address for the write.
REQ-018 Port busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-019 States SHALL be IDLE, REQ, FILL, WRITE; busy, mem_req and cache_write SHALL decode from state only.
REQ-020 IDLE: fetch_req && !cache_valid SHALL latch line_addr = pc_in with low 6 bits cleared and enter REQ next cycle.
REQ-021 REQ: mem_req=1, mem_addr=line_addr; mem_ack SHALL move to FILL with beat_cnt=0; mem_req held until ack.
REQ-022 FILL: each mem_rvalid beat SHALL be stored, beat_cnt increments; the beat completing BEATS SHALL move to WRITE.
REQ-023 Beat k (0 = lowest address) SHALL occupy cache_data[INW-1-k*BEATW -: BEATW]; the lowest-address instruction sits in the MSBs.
REQ-024 WRITE: cache_write=1 for exactly one cycle with cache_data and cache_base_addr=line_addr stable, then IDLE.
REQ-025 Miss-to-mem_req latency SHALL be 1 cycle; last beat to cache_write SHALL be 1 cycle.
REQ-026 mem_rvalid outside FILL SHALL be ignored; mem_ack outside REQ SHALL be ignored.
REQ-027 flush in IDLE SHALL have no effect and SHALL suppress a miss sampled the same cycle.
REQ-028 flush in REQ SHALL return to IDLE next cycle with no request outstanding, unless mem_ack is high that cycle, which is treated as flush in FILL.
REQ-029 flush in FILL SHALL set drop; remaining beats SHALL still be drained, then IDLE without cache_write.
REQ-030 flush in WRITE SHALL not cancel the write.
REQ-031 A new miss SHALL only be accepted in IDLE; a miss on the line just written is not possible because cache_valid rises next cycle.
REQ-032 mem_addr and cache_base_addr SHALL hold line_addr in all states; cache_data holds last assembled line.

Reset
REQ-033 rst SHALL asynchronously force IDLE, beat_cnt=0, drop=0, line_addr=0, cache_data=0, all outputs low/zero.
REQ-034 rst mid-FILL SHALL discard partial data; beats arriving after release SHALL be ignored.

Verification
REQ-035 pc_in=0x0000_0046, fetch_req=1, cache_valid=0 -> next cycle mem_req=1, mem_addr=0x40; ack after 3 cycles -> FILL.
REQ-036 8 beats 0x1111..., 0x2222..., ... 0x8888... with gaps -> cache_write one cycle, cache_data[511:448]=0x1111..., [63:0]=0x8888..., base=0x40.
REQ-037 flush at beat 4 of 8 -> remaining 4 beats drained, no cache_write, busy low after 8th beat.
REQ-038 flush in REQ with mem_ack=0 -> IDLE next cycle, mem_req low, no write.
REQ-039 fetch_req=1, cache_valid=1 -> stays IDLE, mem_req never asserted; stray mem_rvalid ignored.
REQ-040 rst pulse during FILL beat 5 -> all outputs zero immediately, then fresh miss at 0x1000 completes normally.

Source files
------------

// File: rtl/instruction_refill_ctrl.sv
// Instruction cache refill controller: one line read per miss, beats
// assembled MSB-first, a single-cycle line write, and redirect abort.
module instruction_refill_ctrl #(
  parameter int ADDRW = 32,
  parameter int INW   = 512,
  parameter int BEATW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] pc_in,
  input  logic             fetch_req,
  input  logic             cache_valid,
  input  logic             flush,
  output logic             mem_req,
  output logic [ADDRW-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [BEATW-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic             cache_write,
  output logic [INW-1:0]   cache_data,
  output logic [ADDRW-1:0] cache_base_addr,
  output logic             busy
);

  localparam int BEATS = INW / BEATW;
  localparam int OFFW  = $clog2(INW / 8);
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] line_addr_q, line_addr_d;
  logic [CNTW-1:0]  beat_cnt_q, beat_cnt_d;
  logic             drop_q, drop_d;
  logic [INW-1:0]   buf_q, buf_d;
  logic [INW-1:0]   data_q, data_d;
  logic             last_beat;

  assign last_beat = (beat_cnt_q == CNTW'(BEATS - 1));

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    beat_cnt_d  = beat_cnt_q;
    drop_d      = drop_q;
    buf_d       = buf_q;
    data_d      = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_req && !cache_valid && !flush) begin
          line_addr_d = {pc_in[ADDRW-1:OFFW], {OFFW{1'b0}}};
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // An ack coinciding with flush still owes the memory a full burst.
        if (mem_ack) begin
          state_d    = S_FILL;
          beat_cnt_d = '0;
          drop_d     = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt_q == CNTW'(k))
              buf_d[INW-1-k*BEATW -: BEATW] = mem_rdata;
          end
          beat_cnt_d = beat_cnt_q + CNTW'(1);
          if (last_beat) begin
            beat_cnt_d = '0;
            drop_d     = 1'b0;
            if (drop_q || flush) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_WRITE;
              data_d  = buf_d;
            end
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_addr_q <= '0;
      beat_cnt_q  <= '0;
      drop_q      <= 1'b0;
      buf_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      drop_q      <= drop_d;
      buf_q       <= buf_d;
      data_q      <= data_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign mem_req         = (state_q == S_REQ);
  assign cache_write     = (state_q == S_WRITE);
  assign mem_addr        = line_addr_q;
  assign cache_base_addr = line_addr_q;
  assign cache_data      = data_q;

endmodule

// File: tb/tb_instruction_refill_ctrl.sv
// Scoreboarded bench for instruction_refill_ctrl: refills, flushes,
// hits, mid-fill reset and back-to-back misses.
module tb_instruction_refill_ctrl;

  logic         clk;
  logic         rst;
  logic [31:0]  pc_in;
  logic         fetch_req;
  logic         cache_valid;
  logic         flush;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [63:0]  mem_rdata;
  logic         mem_rvalid;
  logic         cache_write;
  logic [511:0] cache_data;
  logic [31:0]  cache_base_addr;
  logic         busy;

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;

  instruction_refill_ctrl dut (
    .clk(clk),
    .rst(rst),
    .pc_in(pc_in),
    .fetch_req(fetch_req),
    .cache_valid(cache_valid),
    .flush(flush),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid),
    .cache_write(cache_write),
    .cache_data(cache_data),
    .cache_base_addr(cache_base_addr),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (cache_write === 1'b1) wr_cnt++;

  function automatic logic [63:0] beat_of(input int k, input int seed);
    logic [3:0]  n;
    logic [31:0] s;
    n = 4'(k + 1);
    s = 32'(seed);
    return {16{n}} ^ {s, s};
  endfunction

  function automatic logic [511:0] line_of(input int seed);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[511-k*64 -: 64] = beat_of(k, seed);
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [31:0] pc);
    pc_in       = pc;
    fetch_req   = 1'b1;
    cache_valid = 1'b0;
    step();
    fetch_req = 1'b0;
  endtask

  task automatic ack_now();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic send_beats(input int first, input int last,
                            input int seed, input int flush_at);
    for (int k = first; k <= last; k++) begin
      mem_rdata  = beat_of(k, seed);
      mem_rvalid = 1'b1;
      flush      = (k == flush_at);
      step();
      mem_rvalid = 1'b0;
      flush      = 1'b0;
      mem_rdata  = 64'hdead_beef_dead_beef;
      if ((k % 3 == 1) && (k != last)) step();
    end
  endtask

  task automatic pop_and_compare(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: cache_write with empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      if (cache_data !== e.data) begin
        errors++;
        $display("FAIL %s_data: got %h want %h", tag, cache_data, e.data);
      end
      checks++;
      if (cache_base_addr !== e.addr) begin
        errors++;
        $display("FAIL %s_base: got %h want %h", tag, cache_base_addr, e.addr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, mem_req, cache_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000", {busy, mem_req, cache_write});
    end
    checks++;
    if ({mem_addr, cache_base_addr} !== 64'h0 || cache_data !== 512'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h want 0", mem_addr, cache_base_addr);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy %b want 0", busy);
    end
  endtask

  task automatic test_basic_refill();
    int  w0;
    logic hold_ok;
    w0 = wr_cnt;
    exp_q.push_back('{32'h40, line_of(0)});
    start_miss(32'h0000_0046);
    checks++;
    if ({mem_req, busy, cache_write} !== 3'b110 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL miss_req: got req %b addr %h want 1 40", mem_req, mem_addr);
    end
    hold_ok = 1'b1;
    repeat (3) begin
      step();
      if (mem_req !== 1'b1) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL req_hold: got %b want 1", hold_ok);
    end
    ack_now();
    checks++;
    if ({mem_req, busy} !== 2'b01) begin
      errors++;
      $display("FAIL fill_enter: got %b want 01", {mem_req, busy});
    end
    send_beats(0, 7, 0, -1);
    checks++;
    if (cache_write !== 1'b1) begin
      errors++;
      $display("FAIL write_lat: got %b want 1", cache_write);
    end
    if (cache_write === 1'b1) pop_and_compare("basic");
    checks++;
    if (cache_data[511:448] !== 64'h1111_1111_1111_1111 ||
        cache_data[63:0] !== 64'h8888_8888_8888_8888) begin
      errors++;
      $display("FAIL beat_order: got %h %h want 1111.. 8888..",
               cache_data[511:448], cache_data[63:0]);
    end
    step();
    checks++;
    if ({cache_write, busy} !== 2'b00 || wr_cnt - w0 != 1) begin
      errors++;
      $display("FAIL write_once: got %b cnt %0d want 00 cnt 1",
               {cache_write, busy}, wr_cnt - w0);
    end
    checks++;
    if (cache_data !== line_of(0)) begin
      errors++;
      $display("FAIL data_hold: got %h want %h", cache_data, line_of(0));
    end
  endtask

  task automatic test_flush_fill();
    int w0;
    w0 = wr_cnt;
    start_miss(32'h0000_2010);
    ack_now();
    send_beats(0, 6, 4, 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_busy: got %b want 1", busy);
    end
    send_beats(7, 7, 4, -1);
    checks++;
    if ({busy, cache_write} !== 2'b00) begin
      errors++;
      $display("FAIL drain_done: got %b want 00", {busy, cache_write});
    end
    step();
    step();
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("FAIL drop_write: got %0d writes want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_flush_req();
    int w0;
    w0 = wr_cnt;
    start_miss(32'h0000_3044);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({mem_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL req_flush: got %b want 00", {mem_req, busy});
    end
    start_miss(32'h0000_3080);
    flush   = 1'b1;
    mem_ack = 1'b1;
    step();
    flush   = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, busy} !== 2'b01) begin
      errors++;
      $display("FAIL ack_flush: got %b want 01", {mem_req, busy});
    end
    send_beats(0, 7, 5, -1);
    step();
    checks++;
    if (busy !== 1'b0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL ack_flush_drop: got busy %b writes %0d want 0 0",
               busy, wr_cnt - w0);
    end
  endtask

  task automatic test_hit();
    int   w0;
    logic quiet;
    w0          = wr_cnt;
    pc_in       = 32'h0000_5000;
    fetch_req   = 1'b1;
    cache_valid = 1'b1;
    mem_rvalid  = 1'b1;
    mem_ack     = 1'b1;
    quiet       = 1'b1;
    repeat (4) begin
      step();
      if (mem_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL hit_idle: got %b want 1", quiet);
    end
    cache_valid = 1'b0;
    flush       = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush_miss: got %b want 0", busy);
    end
    fetch_req  = 1'b0;
    flush      = 1'b0;
    mem_rvalid = 1'b0;
    mem_ack    = 1'b0;
    step();
    checks++;
    if (mem_addr !== 32'h0000_3080 || wr_cnt != w0) begin
      errors++;
      $display("FAIL addr_hold: got %h writes %0d want 3080 0",
               mem_addr, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_fill();
    start_miss(32'h0000_6000);
    ack_now();
    send_beats(0, 3, 7, -1);
    mem_rdata  = beat_of(4, 7);
    mem_rvalid = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_req, cache_write} !== 3'b000 || mem_addr !== 32'h0 ||
        cache_base_addr !== 32'h0 || cache_data !== 512'h0) begin
      errors++;
      $display("FAIL async_rst: got %b %h want 000 0",
               {busy, mem_req, cache_write}, mem_addr);
    end
    step();
    rst = 1'b0;
    repeat (3) step();
    mem_rvalid = 1'b0;
    checks++;
    if (busy !== 1'b0 || cache_data !== 512'h0) begin
      errors++;
      $display("FAIL post_rst_beats: got busy %b want 0", busy);
    end
    exp_q.push_back('{32'h1000, line_of(9)});
    start_miss(32'h0000_1004);
    checks++;
    if (mem_addr !== 32'h1000) begin
      errors++;
      $display("FAIL fresh_addr: got %h want 1000", mem_addr);
    end
    ack_now();
    send_beats(0, 7, 9, -1);
    checks++;
    if (cache_write !== 1'b1) begin
      errors++;
      $display("FAIL fresh_write: got %b want 1", cache_write);
    end
    if (cache_write === 1'b1) pop_and_compare("fresh");
    step();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{32'h7000, line_of(3)});
    start_miss(32'h0000_7000);
    ack_now();
    send_beats(0, 7, 3, -1);
    checks++;
    if (cache_write !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write_a: got %b want 1", cache_write);
    end
    if (cache_write === 1'b1) pop_and_compare("b2b_a");
    pc_in       = 32'h0000_7400;
    fetch_req   = 1'b1;
    cache_valid = 1'b0;
    flush       = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({busy, cache_write} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_no_accept: got %b want 00", {busy, cache_write});
    end
    exp_q.push_back('{32'h7400, line_of(6)});
    step();
    fetch_req = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h7400) begin
      errors++;
      $display("FAIL b2b_req_b: got %b %h want 1 7400", mem_req, mem_addr);
    end
    ack_now();
    send_beats(0, 7, 6, -1);
    checks++;
    if (cache_write !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write_b: got %b want 1", cache_write);
    end
    if (cache_write === 1'b1) pop_and_compare("b2b_b");
    step();
  endtask

  initial begin
    rst         = 1'b1;
    pc_in       = '0;
    fetch_req   = 1'b0;
    cache_valid = 1'b0;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    mem_rvalid  = 1'b0;
    test_reset();
    test_basic_refill();
    test_flush_fill();
    test_flush_req();
    test_hit();
    test_reset_fill();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
